// File: rtl/sata_link_pkg.sv
// Shared SATA link definitions: primitive dword encodings, primitive enum and lookup helpers.
package sata_link_pkg;

    localparam int unsigned SLIP_W = 3;

    localparam logic [31:0] DW_ALIGN   = 32'h7B4A_4ABC;
    localparam logic [31:0] DW_SYNC    = 32'hB5B5_957C;
    localparam logic [31:0] DW_X_RDY   = 32'h5757_B57C;
    localparam logic [31:0] DW_R_RDY   = 32'h4A4A_957C;
    localparam logic [31:0] DW_R_IP    = 32'h5555_B57C;
    localparam logic [31:0] DW_R_OK    = 32'h3535_B57C;
    localparam logic [31:0] DW_R_ERR   = 32'h5656_B57C;
    localparam logic [31:0] DW_SOF     = 32'h3737_B57C;
    localparam logic [31:0] DW_EOF     = 32'hD5D5_B57C;
    localparam logic [31:0] DW_WTRM    = 32'h5858_B57C;
    localparam logic [31:0] DW_HOLD    = 32'hD5D5_AA7C;
    localparam logic [31:0] DW_HOLDA   = 32'h9595_AA7C;
    localparam logic [31:0] DW_CONT    = 32'h9999_AA7C;
    localparam logic [31:0] DW_DMAT    = 32'h3636_B57C;
    localparam logic [31:0] DW_PMREQ_P = 32'h1717_B57C;
    localparam logic [31:0] DW_PMREQ_S = 32'h7575_957C;
    localparam logic [31:0] DW_PMACK   = 32'h9595_957C;
    localparam logic [31:0] DW_PMNAK   = 32'hF5F5_957C;

    typedef enum logic [4:0] {
        PRIM_NONE    = 5'd0,
        PRIM_ALIGN   = 5'd1,
        PRIM_SYNC    = 5'd2,
        PRIM_X_RDY   = 5'd3,
        PRIM_R_RDY   = 5'd4,
        PRIM_R_IP    = 5'd5,
        PRIM_R_OK    = 5'd6,
        PRIM_R_ERR   = 5'd7,
        PRIM_SOF     = 5'd8,
        PRIM_EOF     = 5'd9,
        PRIM_WTRM    = 5'd10,
        PRIM_HOLD    = 5'd11,
        PRIM_HOLDA   = 5'd12,
        PRIM_CONT    = 5'd13,
        PRIM_DMAT    = 5'd14,
        PRIM_PMREQ_P = 5'd15,
        PRIM_PMREQ_S = 5'd16,
        PRIM_PMACK   = 5'd17,
        PRIM_PMNAK   = 5'd18,
        PRIM_UNKNOWN = 5'd31
    } prim_e;

    function automatic logic is_k28(input logic [7:0] b);
        return (b == 8'hBC) || (b == 8'h7C);
    endfunction

    function automatic prim_e prim_lookup(input logic [31:0] dw);
        prim_e p;
        case (dw)
            DW_ALIGN:   p = PRIM_ALIGN;
            DW_SYNC:    p = PRIM_SYNC;
            DW_X_RDY:   p = PRIM_X_RDY;
            DW_R_RDY:   p = PRIM_R_RDY;
            DW_R_IP:    p = PRIM_R_IP;
            DW_R_OK:    p = PRIM_R_OK;
            DW_R_ERR:   p = PRIM_R_ERR;
            DW_SOF:     p = PRIM_SOF;
            DW_EOF:     p = PRIM_EOF;
            DW_WTRM:    p = PRIM_WTRM;
            DW_HOLD:    p = PRIM_HOLD;
            DW_HOLDA:   p = PRIM_HOLDA;
            DW_CONT:    p = PRIM_CONT;
            DW_DMAT:    p = PRIM_DMAT;
            DW_PMREQ_P: p = PRIM_PMREQ_P;
            DW_PMREQ_S: p = PRIM_PMREQ_S;
            DW_PMACK:   p = PRIM_PMACK;
            DW_PMNAK:   p = PRIM_PMNAK;
            default:    p = PRIM_UNKNOWN;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sata_rx_prim_decode.sv
// Combinational classifier: assembled dword + per-byte K flags -> primitive flag, code, K error.
module sata_rx_prim_decode
    import sata_link_pkg::*;
(
    input  logic [31:0] dword,
    input  logic [3:0]  charisk,
    output logic        is_prim,
    output prim_e       code,
    output logic        k_err
);

    always_comb begin
        is_prim = (charisk == 4'b0001);
        k_err   = !is_prim && (charisk != 4'b0000);
        code    = is_prim ? prim_lookup(dword) : PRIM_NONE;
    end

endmodule

// File: rtl/sata_rx_dword_decoder.sv
// RX halfword-to-dword rebuilder with phase lock, ALIGN drop and CONT expansion.
// Optional saturating error counter enabled by SATA_RX_ERR_CNT_EN.
module sata_rx_dword_decoder
    import sata_link_pkg::*;
#(
    parameter int unsigned SLIP_THRESH = 3
) (
    input  logic        phy_clk,
    input  logic        reset_n,
    input  logic        linkup,
    input  logic [15:0] rx_data_in,
    input  logic [1:0]  rx_charisk_in,
    input  logic        decerr,
    output logic [31:0] rx_dw_out,
    output logic        rx_dw_vld,
    output logic [4:0]  rx_prim_code,
    output logic        rx_prim_vld,
    output logic        align_det_t,
    output logic        dw_locked,
    output logic        rx_err_t,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {StHunt, StLo, StHi} state_e;

    state_e             state_q, state_d;
    logic [15:0]        lo_data_q, lo_data_d;
    logic [1:0]         lo_k_q, lo_k_d;
    logic               lo_err_q, lo_err_d;
    logic [SLIP_W-1:0]  slip_q, slip_d;
    logic               locked_q, locked_d;
    prim_e              last_q, last_d;
    logic               cont_q, cont_d;
    logic [31:0]        dw_q, dw_d;
    prim_e              code_q, code_d;
    logic               dw_vld_q, dw_vld_d;
    logic               prim_vld_q, prim_vld_d;
    logic               align_q, align_d;
    logic               err_q, err_d;

    logic [31:0]        asm_dw;
    logic [3:0]         asm_k;
    logic               hw_k28;
    logic [SLIP_W-1:0]  slip_inc;
    logic               dec_is_prim;
    prim_e              dec_code;
    logic               dec_k_err;

    assign asm_dw   = {rx_data_in, lo_data_q};
    assign asm_k    = {rx_charisk_in, lo_k_q};
    assign hw_k28   = (rx_charisk_in == 2'b01) && is_k28(rx_data_in[7:0]);
    assign slip_inc = slip_q + 1'b1;

    sata_rx_prim_decode u_prim_decode (
        .dword   (asm_dw),
        .charisk (asm_k),
        .is_prim (dec_is_prim),
        .code    (dec_code),
        .k_err   (dec_k_err)
    );

    always_comb begin
        state_d    = state_q;
        lo_data_d  = lo_data_q;
        lo_k_d     = lo_k_q;
        lo_err_d   = lo_err_q;
        slip_d     = slip_q;
        locked_d   = locked_q;
        last_d     = last_q;
        cont_d     = cont_q;
        dw_d       = dw_q;
        code_d     = code_q;
        dw_vld_d   = 1'b0;
        prim_vld_d = 1'b0;
        align_d    = 1'b0;
        err_d      = 1'b0;

        if (!linkup) begin
            state_d   = StHunt;
            lo_data_d = '0;
            lo_k_d    = '0;
            lo_err_d  = 1'b0;
            slip_d    = '0;
            locked_d  = 1'b0;
            last_d    = PRIM_NONE;
            cont_d    = 1'b0;
            dw_d      = '0;
            code_d    = PRIM_NONE;
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (hw_k28) begin
                        lo_data_d = rx_data_in;
                        lo_k_d    = rx_charisk_in;
                        lo_err_d  = decerr;
                        state_d   = StHi;
                    end
                end
                StLo: begin
                    lo_data_d = rx_data_in;
                    lo_k_d    = rx_charisk_in;
                    lo_err_d  = decerr;
                    state_d   = StHi;
                    if (hw_k28) slip_d = '0;
                end
                StHi: begin
                    state_d  = StLo;
                    locked_d = 1'b1;
                    dw_d     = asm_dw;
                    if (dec_k_err) begin
                        err_d = 1'b1;
                    end else if (dec_is_prim) begin
                        case (dec_code)
                            PRIM_ALIGN: align_d = 1'b1;
                            PRIM_CONT: begin
                                if (last_q == PRIM_NONE) err_d  = 1'b1;
                                else                     cont_d = 1'b1;
                            end
                            // Unknown codes break the run and cannot be repeated by a later CONT
                            PRIM_UNKNOWN: begin
                                err_d      = 1'b1;
                                prim_vld_d = 1'b1;
                                code_d     = PRIM_UNKNOWN;
                                last_d     = PRIM_NONE;
                                cont_d     = 1'b0;
                            end
                            default: begin
                                prim_vld_d = 1'b1;
                                code_d     = dec_code;
                                last_d     = dec_code;
                                cont_d     = 1'b0;
                            end
                        endcase
                    end else if (cont_q) begin
                        prim_vld_d = 1'b1;
                        code_d     = last_q;
                    end else begin
                        dw_vld_d = 1'b1;
                    end
                    if (decerr || lo_err_q) err_d = 1'b1;
                    // K28.x in the high slot means our phase is off by one halfword
                    if (hw_k28) begin
                        if (slip_inc == SLIP_W'(SLIP_THRESH)) begin
                            state_d  = StHunt;
                            locked_d = 1'b0;
                            cont_d   = 1'b0;
                            last_d   = PRIM_NONE;
                            slip_d   = '0;
                        end else begin
                            slip_d = slip_inc;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StHunt;
            lo_data_q  <= '0;
            lo_k_q     <= '0;
            lo_err_q   <= 1'b0;
            slip_q     <= '0;
            locked_q   <= 1'b0;
            last_q     <= PRIM_NONE;
            cont_q     <= 1'b0;
            dw_q       <= '0;
            code_q     <= PRIM_NONE;
            dw_vld_q   <= 1'b0;
            prim_vld_q <= 1'b0;
            align_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_data_q  <= lo_data_d;
            lo_k_q     <= lo_k_d;
            lo_err_q   <= lo_err_d;
            slip_q     <= slip_d;
            locked_q   <= locked_d;
            last_q     <= last_d;
            cont_q     <= cont_d;
            dw_q       <= dw_d;
            code_q     <= code_d;
            dw_vld_q   <= dw_vld_d;
            prim_vld_q <= prim_vld_d;
            align_q    <= align_d;
            err_q      <= err_d;
        end
    end

`ifdef SATA_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Counts alongside the pulse; survives LINKUP drops
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0;
`endif

    assign rx_dw_out    = dw_q;
    assign rx_dw_vld    = dw_vld_q;
    assign rx_prim_code = code_q;
    assign rx_prim_vld  = prim_vld_q;
    assign align_det_t  = align_q;
    assign dw_locked    = locked_q;
    assign rx_err_t     = err_q;

endmodule

// File: tb/tb_sata_rx_dword_decoder.sv
// Table-driven bench: one row per PHY halfword, expected outputs sampled on the following negedge.
module tb_sata_rx_dword_decoder;

    localparam logic [4:0] C_NONE  = 5'd0;
    localparam logic [4:0] C_SYNC  = 5'd2;
    localparam logic [4:0] C_XRDY  = 5'd3;
    localparam logic [4:0] C_SOF   = 5'd8;
    localparam logic [4:0] C_EOF   = 5'd9;
    localparam logic [4:0] C_HOLD  = 5'd11;
    localparam logic [4:0] C_HOLDA = 5'd12;
    localparam logic [4:0] C_UNK   = 5'd31;

    localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] P_XRDY  = 32'h5757B57C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] P_HOLDA = 32'h9595AA7C;
    localparam logic [31:0] P_CONT  = 32'h9999AA7C;
    localparam logic [31:0] P_SOF   = 32'h3737B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5B57C;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  k;
        logic        err;
        logic        lnk;
        logic        dv;
        logic        pv;
        logic [4:0]  pc;
        logic        al;
        logic        er;
        logic        lk;
        logic [31:0] dw;
    } vec_t;

    logic        phy_clk = 1'b0;
    logic        reset_n;
    logic        linkup;
    logic [15:0] rx_data_in;
    logic [1:0]  rx_charisk_in;
    logic        decerr;
    logic [31:0] rx_dw_out;
    logic        rx_dw_vld;
    logic [4:0]  rx_prim_code;
    logic        rx_prim_vld;
    logic        align_det_t;
    logic        dw_locked;
    logic        rx_err_t;
    logic [15:0] err_cnt;

    vec_t        tbl[$];
    logic [4:0]  held_code = 5'd0;
    logic        held_lk = 1'b0;
    int          exp_errs = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] junk[5] = '{32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0, 32'hFEDCBA98};

    always #5 phy_clk = ~phy_clk;

    sata_rx_dword_decoder #(.SLIP_THRESH(3)) dut (
        .phy_clk       (phy_clk),
        .reset_n       (reset_n),
        .linkup        (linkup),
        .rx_data_in    (rx_data_in),
        .rx_charisk_in (rx_charisk_in),
        .decerr        (decerr),
        .rx_dw_out     (rx_dw_out),
        .rx_dw_vld     (rx_dw_vld),
        .rx_prim_code  (rx_prim_code),
        .rx_prim_vld   (rx_prim_vld),
        .align_det_t   (align_det_t),
        .dw_locked     (dw_locked),
        .rx_err_t      (rx_err_t),
        .err_cnt       (err_cnt)
    );

    task automatic add_hw(input logic [15:0] data, input logic [1:0] k, input logic err,
                          input logic lnk, input logic dv, input logic pv, input logic [4:0] pc,
                          input logic al, input logic er, input logic lk, input logic [31:0] dw);
        vec_t v;
        if (!lnk) held_code = C_NONE;
        else if (pv) held_code = pc;
        held_lk = lk;
        if (er) exp_errs++;
        v = '{data: data, k: k, err: err, lnk: lnk, dv: dv, pv: pv, pc: held_code,
              al: al, er: er, lk: lk, dw: dw};
        tbl.push_back(v);
    endtask

    task automatic add_dw(input logic [31:0] d, input logic [3:0] k, input logic hierr,
                          input logic dv, input logic pv, input logic [4:0] pc,
                          input logic al, input logic er);
        add_hw(d[15:0], k[1:0], 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0, held_lk, 32'h0);
        add_hw(d[31:16], k[3:2], hierr, 1'b1, dv, pv, pc, al, er, 1'b1, d);
    endtask

    task automatic add_prim(input logic [31:0] d, input logic [4:0] pc);
        add_dw(d, 4'b0001, 1'b0, 1'b0, 1'b1, pc, 1'b0, 1'b0);
    endtask

    task automatic add_align();
        add_dw(P_ALIGN, 4'b0001, 1'b0, 1'b0, 1'b0, C_NONE, 1'b1, 1'b0);
    endtask

    task automatic add_data(input logic [31:0] d);
        add_dw(d, 4'b0000, 1'b0, 1'b1, 1'b0, C_NONE, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic build_table();
        // Lock on a SYNC stream entered at a high half
        add_hw(16'hB5B5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) add_prim(P_SYNC, C_SYNC);
        // ALIGN drop
        add_prim(P_XRDY, C_XRDY);
        add_align();
        add_align();
        add_prim(P_XRDY, C_XRDY);
        // CONT run with junk and an ALIGN inside
        add_prim(P_HOLD, C_HOLD);
        add_prim(P_HOLD, C_HOLD);
        add_dw(P_CONT, 4'b0001, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) add_dw(junk[i], 4'b0000, 1'b0, 1'b0, 1'b1, C_HOLD, 1'b0, 1'b0);
        add_align();
        add_prim(P_HOLDA, C_HOLDA);
        // Repeated CONT is ignored; SYNC ends the run; data flows again
        add_dw(P_CONT, 4'b0001, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0);
        add_dw(P_CONT, 4'b0001, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0);
        add_dw(32'h55AA33CC, 4'b0000, 1'b0, 1'b0, 1'b1, C_HOLDA, 1'b0, 1'b0);
        add_prim(P_SYNC, C_SYNC);
        add_data(32'h0BADCAFE);
        // Frame
        add_prim(P_SOF, C_SOF);
        add_data(32'h12345678);
        add_data(32'hDEADBEEF);
        add_prim(P_EOF, C_EOF);
        // Errors: DECERR on data, illegal K placement, unknown primitive
        add_dw(32'hCAFEF00D, 4'b0000, 1'b1, 1'b1, 1'b0, C_NONE, 1'b0, 1'b1);
        add_dw(32'h11223344, 4'b0010, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b1);
        add_dw(32'h1234567C, 4'b0001, 1'b0, 1'b0, 1'b1, C_UNK, 1'b0, 1'b1);
        // LINKUP low mid-frame clears everything
        add_prim(P_SOF, C_SOF);
        add_hw(16'h5555, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 1'b1, 32'h0);
        add_hw(16'h6666, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        add_hw(16'h7777, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        add_align();
        // Phase slip: K28.5 lands in the high slot three times
        add_hw(16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            add_hw(16'h4ABC, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, 1'b0, 1'b1, (i < 2), 32'h0);
            add_hw(16'h7B4A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0, (i < 2), 32'h0);
        end
        add_align();
        add_dw(P_CONT, 4'b0001, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b1);
        add_prim(P_SYNC, C_SYNC);
    endtask

    initial begin
        reset_n       = 1'b0;
        linkup        = 1'b0;
        rx_data_in    = '0;
        rx_charisk_in = '0;
        decerr        = 1'b0;
        build_table();

        #3;
        check("reset_dw_out", rx_dw_out, 32'h0);
        check("reset_pulses", {28'h0, rx_dw_vld, rx_prim_vld, align_det_t, rx_err_t}, 32'h0);
        check("reset_prim_code", {27'h0, rx_prim_code}, {27'h0, C_NONE});
        check("reset_locked", {31'h0, dw_locked}, 32'h0);
        check("reset_err_cnt", {16'h0, err_cnt}, 32'h0);

        @(negedge phy_clk);
        reset_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            rx_data_in    = tbl[i].data;
            rx_charisk_in = tbl[i].k;
            decerr        = tbl[i].err;
            linkup        = tbl[i].lnk;
            @(negedge phy_clk);
            n_vec++;
            if ({rx_dw_vld, rx_prim_vld, rx_prim_code, align_det_t, dw_locked, rx_err_t} !==
                {tbl[i].dv, tbl[i].pv, tbl[i].pc, tbl[i].al, tbl[i].lk, tbl[i].er} ||
                (tbl[i].dv && rx_dw_out !== tbl[i].dw)) begin
                n_err++;
                $display("FAIL row %0d: got dv=%b pv=%b code=%0d al=%b lk=%b er=%b dw=%h, required dv=%b pv=%b code=%0d al=%b lk=%b er=%b dw=%h",
                         i, rx_dw_vld, rx_prim_vld, rx_prim_code, align_det_t, dw_locked, rx_err_t,
                         rx_dw_out, tbl[i].dv, tbl[i].pv, tbl[i].pc, tbl[i].al, tbl[i].lk,
                         tbl[i].er, tbl[i].dw);
            end
        end

`ifdef SATA_RX_ERR_CNT_EN
        check("err_cnt_total", {16'h0, err_cnt}, exp_errs);
`else
        check("err_cnt_tied", {16'h0, err_cnt}, 32'h0);
`endif

        // Asynchronous reset between clock edges
        #2 reset_n = 1'b0;
        #1;
        check("async_dw_out", rx_dw_out, 32'h0);
        check("async_prim_code", {27'h0, rx_prim_code}, {27'h0, C_NONE});
        check("async_locked", {31'h0, dw_locked}, 32'h0);
        check("async_err_cnt", {16'h0, err_cnt}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
